// File: rtl/db_req_arbiter.sv
// Round-robin arbiter sharing one db_cont lookup/update engine between two request ports.
// Optional grant/hit statistics counters are enabled by defining DB_ARB_STATS_EN.
module db_req_arbiter #(
   parameter int HASH_SIZE  = 32,
   parameter int KEY_SIZE   = 96,
   parameter int VAL_SIZE   = 32,
   parameter int SETUP_CYC  = 1,
   parameter int WINDOW_CYC = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 p0_valid,
   output logic                 p0_ready,
   input  logic [3:0]           p0_op,
   input  logic [HASH_SIZE-1:0] p0_hash,
   input  logic [KEY_SIZE-1:0]  p0_key,
   input  logic [VAL_SIZE-1:0]  p0_value,
   output logic                 p0_resp_valid,
   output logic                 p0_resp_hit,
   output logic [3:0]           p0_resp_flag,
   input  logic                 p1_valid,
   output logic                 p1_ready,
   input  logic [3:0]           p1_op,
   input  logic [HASH_SIZE-1:0] p1_hash,
   input  logic [KEY_SIZE-1:0]  p1_key,
   input  logic [VAL_SIZE-1:0]  p1_value,
   output logic                 p1_resp_valid,
   output logic                 p1_resp_hit,
   output logic [3:0]           p1_resp_flag,
   output logic                 db_in_valid,
   output logic [3:0]           db_in_op,
   output logic [HASH_SIZE-1:0] db_in_hash,
   output logic [KEY_SIZE-1:0]  db_in_key,
   output logic [VAL_SIZE-1:0]  db_in_value,
   input  logic                 db_out_valid,
   input  logic [3:0]           db_out_flag
`ifdef DB_ARB_STATS_EN
   ,
   output logic [15:0]          stat_p0_cnt,
   output logic [15:0]          stat_p1_cnt,
   output logic [15:0]          stat_hit_cnt
`endif
);

   // state   | meaning
   // S_IDLE  | engine free, arbitrate and accept one request
   // S_SETUP | db_in_* driven, waiting out DPRAM read latency
   // S_ISSUE | one-cycle db_in_valid pulse
   // S_WAIT  | guard window, collect engine out_valid/out_flag
   // S_RESP  | one-cycle response to the owning port
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0] SETUP_LOAD = 2'(SETUP_CYC - 1);
   localparam logic [3:0] WIN_LOAD   = 4'(WINDOW_CYC - 1);

   state_t               state_q, state_d;
   logic [1:0]           setup_cnt_q, setup_cnt_d;
   logic [3:0]           win_cnt_q, win_cnt_d;
   logic                 owner_q, owner_d;
   logic                 last_grant_q, last_grant_d;
   logic                 hit_q, hit_d;
   logic [3:0]           flag_q, flag_d;
   logic [3:0]           op_q, op_d;
   logic [HASH_SIZE-1:0] hash_q, hash_d;
   logic [KEY_SIZE-1:0]  key_q, key_d;
   logic [VAL_SIZE-1:0]  value_q, value_d;
   logic                 grant0, grant1;

   always_comb begin
      state_d      = state_q;
      setup_cnt_d  = setup_cnt_q;
      win_cnt_d    = win_cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      hit_d        = hit_q;
      flag_d       = flag_q;
      op_d         = op_q;
      hash_d       = hash_q;
      key_d        = key_q;
      value_d      = value_q;
      grant0       = 1'b0;
      grant1       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // No acceptance while reset is held, so no handshake can be lost.
            if (rst) begin
               if (p0_valid && (!p1_valid || last_grant_q)) grant0 = 1'b1;
               else if (p1_valid)                           grant1 = 1'b1;
            end
            if (grant0 || grant1) begin
               owner_d      = grant1;
               last_grant_d = grant1;
               op_d         = grant1 ? p1_op    : p0_op;
               hash_d       = grant1 ? p1_hash  : p0_hash;
               key_d        = grant1 ? p1_key   : p0_key;
               value_d      = grant1 ? p1_value : p0_value;
               setup_cnt_d  = SETUP_LOAD;
               state_d      = S_SETUP;
            end
         end
         S_SETUP: begin
            if (setup_cnt_q == 2'd0) state_d = S_ISSUE;
            else                     setup_cnt_d = setup_cnt_q - 2'd1;
         end
         S_ISSUE: begin
            win_cnt_d = WIN_LOAD;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (db_out_valid) begin
               hit_d  = 1'b1;
               flag_d = db_out_flag;
            end
            if (win_cnt_q == 4'd0) state_d = S_RESP;
            else                   win_cnt_d = win_cnt_q - 4'd1;
         end
         S_RESP: begin
            hit_d   = 1'b0;
            flag_d  = 4'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         setup_cnt_q  <= '0;
         win_cnt_q    <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         hit_q        <= 1'b0;
         flag_q       <= '0;
         op_q         <= '0;
         hash_q       <= '0;
         key_q        <= '0;
         value_q      <= '0;
      end else begin
         state_q      <= state_d;
         setup_cnt_q  <= setup_cnt_d;
         win_cnt_q    <= win_cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         hit_q        <= hit_d;
         flag_q       <= flag_d;
         op_q         <= op_d;
         hash_q       <= hash_d;
         key_q        <= key_d;
         value_q      <= value_d;
      end
   end

   assign p0_ready      = grant0;
   assign p1_ready      = grant1;
   assign db_in_valid   = (state_q == S_ISSUE);
   assign db_in_op      = op_q;
   assign db_in_hash    = hash_q;
   assign db_in_key     = key_q;
   assign db_in_value   = value_q;
   assign p0_resp_valid = (state_q == S_RESP) && !owner_q;
   assign p1_resp_valid = (state_q == S_RESP) && owner_q;
   assign p0_resp_hit   = p0_resp_valid && hit_q;
   assign p1_resp_hit   = p1_resp_valid && hit_q;
   assign p0_resp_flag  = p0_resp_valid ? flag_q : 4'd0;
   assign p1_resp_flag  = p1_resp_valid ? flag_q : 4'd0;

`ifdef DB_ARB_STATS_EN
   logic [15:0] stat_p0_q, stat_p1_q, stat_hit_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_p0_q  <= '0;
         stat_p1_q  <= '0;
         stat_hit_q <= '0;
      end else begin
         if (grant0) stat_p0_q <= stat_p0_q + 16'd1;
         if (grant1) stat_p1_q <= stat_p1_q + 16'd1;
         if ((state_q == S_RESP) && hit_q) stat_hit_q <= stat_hit_q + 16'd1;
      end
   end

   assign stat_p0_cnt  = stat_p0_q;
   assign stat_p1_cnt  = stat_p1_q;
   assign stat_hit_cnt = stat_hit_q;
`endif

endmodule
